// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Multi-cycle owner of the shared ALU datapath. Accepts one
//                (opcode, A, B) request, holds the ALU inputs for an
//                opcode-dependent settling time, captures the 64-bit Zin
//                result into HI/LO and offers it on a valid/ready handshake.
//  Options     : ALU_DIVZ_TRAP_EN - adds div_zero output; DIV by zero skips
//                EXEC and completes immediately with a zero result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_zin,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_illegal,
    output logic        busy
`ifdef ALU_DIVZ_TRAP_EN
    ,
    output logic        div_zero
`endif
);

    // ALU opcode encodings
    localparam logic [4:0] C_OP_ADD  = 5'b01100;
    localparam logic [4:0] C_OP_SUB  = 5'b00100;
    localparam logic [4:0] C_OP_AND  = 5'b01010;
    localparam logic [4:0] C_OP_OR   = 5'b01011;
    localparam logic [4:0] C_OP_NOT  = 5'b10010;
    localparam logic [4:0] C_OP_NEG  = 5'b10001;
    localparam logic [4:0] C_OP_ROR  = 5'b01000;
    localparam logic [4:0] C_OP_ROL  = 5'b01001;
    localparam logic [4:0] C_OP_SHL  = 5'b00111;
    localparam logic [4:0] C_OP_SHR  = 5'b00101;
    localparam logic [4:0] C_OP_SHRA = 5'b00110;
    localparam logic [4:0] C_OP_MUL  = 5'b01111;
    localparam logic [4:0] C_OP_DIV  = 5'b00001;

    // Counter reload values (latency minus one); a zero latency behaves as one
    localparam logic [7:0] C_MUL_LAT_M1 = (MUL_CYCLES == 0) ? 8'd0 : 8'(MUL_CYCLES - 1);
    localparam logic [7:0] C_DIV_LAT_M1 = (DIV_CYCLES == 0) ? 8'd0 : 8'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  count_q;
    logic [4:0]  opcode_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        illegal_q;
    logic        res_valid_q;
    logic        req_ready_q;
    logic        busy_q;

    logic        w_legal;
    logic [7:0]  w_lat_m1;
    logic        w_divz_trap;

    // Decode the incoming opcode into legality and settling-counter reload
    always_comb begin
        w_legal  = 1'b1;
        w_lat_m1 = 8'd0;
        case (req_opcode)
            C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_NOT, C_OP_NEG,
            C_OP_ROR, C_OP_ROL, C_OP_SHL, C_OP_SHR, C_OP_SHRA: w_lat_m1 = 8'd0;
            C_OP_MUL: w_lat_m1 = C_MUL_LAT_M1;
            C_OP_DIV: w_lat_m1 = C_DIV_LAT_M1;
            default:  w_legal  = 1'b0;
        endcase
    end

`ifdef ALU_DIVZ_TRAP_EN
    logic div_zero_q;
    assign w_divz_trap = (req_opcode == C_OP_DIV) && (req_b == 32'd0);
`else
    assign w_divz_trap = 1'b0;
`endif

    // Sequencer FSM: acceptance, settling countdown, result capture and hold
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            count_q     <= 8'd0;
            opcode_q    <= 5'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            illegal_q   <= 1'b0;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef ALU_DIVZ_TRAP_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        opcode_q    <= req_opcode;
                        a_q         <= req_a;
                        b_q         <= req_b;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef ALU_DIVZ_TRAP_EN
                        div_zero_q  <= w_divz_trap;
`endif
                        if (w_divz_trap) begin
                            // Divide-by-zero trap completes without touching the ALU
                            state_q     <= ST_DONE;
                            count_q     <= 8'd0;
                            hi_q        <= 32'd0;
                            lo_q        <= 32'd0;
                            illegal_q   <= 1'b0;
                            res_valid_q <= 1'b1;
                        end else if (!w_legal) begin
                            // Unsupported opcode completes immediately with a zero result
                            state_q     <= ST_DONE;
                            count_q     <= 8'd0;
                            hi_q        <= 32'd0;
                            lo_q        <= 32'd0;
                            illegal_q   <= 1'b1;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ST_EXEC;
                            count_q     <= w_lat_m1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (count_q != 8'd0) begin
                        count_q <= count_q - 8'd1;
                    end else begin
                        // Last settling cycle: the ALU output is valid at this edge
                        hi_q        <= alu_zin[63:32];
                        lo_q        <= alu_zin[31:0];
                        illegal_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // New requests are only seen in IDLE, so release does not overlap acceptance
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    count_q     <= 8'd0;
                    res_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign alu_opcode  = opcode_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign res_valid   = res_valid_q;
    assign res_hi      = hi_q;
    assign res_lo      = lo_q;
    assign res_illegal = illegal_q;
`ifdef ALU_DIVZ_TRAP_EN
    assign div_zero    = div_zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Self-checking bench for alu_op_sequencer: table of directed
//                operations plus hand-written backpressure and reset cases.
//                Honours ALU_DIVZ_TRAP_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_zin;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_illegal;
    logic        busy;
`ifdef ALU_DIVZ_TRAP_EN
    logic        div_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    alu_op_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .clock       (clock),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_zin     (alu_zin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .res_illegal (res_illegal),
        .busy        (busy)
`ifdef ALU_DIVZ_TRAP_EN
        ,
        .div_zero    (div_zero)
`endif
    );

    // Behavioural ALU feeding Zin from whatever the sequencer drives
    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  s;
        s = b[4:0];
        case (op)
            5'b01100: r = a + b;
            5'b00100: r = a - b;
            5'b01010: r = a & b;
            5'b01011: r = a | b;
            5'b10010: r = ~a;
            5'b10001: r = -a;
            5'b01000: r = (a >> s) | (a << (6'd32 - {1'b0, s}));
            5'b01001: r = (a << s) | (a >> (6'd32 - {1'b0, s}));
            5'b00111: r = a << s;
            5'b00101: r = a >> s;
            5'b00110: r = $signed(a) >>> s;
            5'b01111: return {32'd0, a} * {32'd0, b};
            5'b00001: begin
                if (b == 32'd0) return 64'hDEAD_0000_0000_BEEF;
                return {a % b, a / b};
            end
            default:  return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return {32'd0, r};
    endfunction

    assign alu_zin = alu_model(alu_opcode, alu_a, alu_b);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[20];
    int   n_vecs;

    // Wait (bounded) at negedges for res_valid; checks in-flight invariants
    task automatic wait_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clock);
            n++;
            if (res_valid) begin
                got = 1'b1;
            end else begin
                check("exec busy", 64'(busy), 64'd1);
                check("exec req_ready", 64'(req_ready), 64'd0);
                check("exec alu_opcode", 64'(alu_opcode), 64'(op));
                check("exec alu_a", 64'(alu_a), 64'(a));
                check("exec alu_b", 64'(alu_b), 64'(b));
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit got;
        @(negedge clock);
        req_opcode = v.op;
        req_a      = v.a;
        req_b      = v.b;
        req_valid  = 1'b1;
        check("idle req_ready", 64'(req_ready), 64'd1);
        @(posedge clock);
        #1;
        // Scramble the request bus; it must be ignored once accepted
        req_valid  = 1'b0;
        req_opcode = 5'b11111;
        req_a      = 32'hFFFF_FFFF;
        req_b      = 32'hFFFF_FFFF;
        wait_result(v.op, v.a, v.b, n, got);
        check("latency", 64'(n), 64'(v.lat));
        if (got) begin
            check("res_hi", 64'(res_hi), 64'(v.hi));
            check("res_lo", 64'(res_lo), 64'(v.lo));
            check("res_illegal", 64'(res_illegal), 64'(v.ill));
            check("done req_ready", 64'(req_ready), 64'd0);
            check("done alu_opcode", 64'(alu_opcode), 64'(v.op));
`ifdef ALU_DIVZ_TRAP_EN
            check("div_zero", 64'(div_zero), 64'(v.dz));
`endif
        end
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        @(negedge clock);
        check("release res_valid", 64'(res_valid), 64'd0);
        check("release req_ready", 64'(req_ready), 64'd1);
        check("release busy", 64'(busy), 64'd0);
    endtask

    // Global safety net so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  got;
        // Vector table: hand-computed results; lat counts cycles after the acceptance edge
        n_vecs = 0;
        vecs[n_vecs++] = '{5'b01100, 32'd5,          32'd7,          32'd0, 32'd12,          1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b00100, 32'd10,         32'd3,          32'd0, 32'd7,           1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b01010, 32'hF0F0_1234,  32'h0FF0_FF00,  32'd0, 32'h00F0_1200,   1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b01011, 32'hF000_0000,  32'h0000_000F,  32'd0, 32'hF000_000F,   1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b10010, 32'h0000_FFFF,  32'd0,          32'd0, 32'hFFFF_0000,   1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b10001, 32'd1,          32'd0,          32'd0, 32'hFFFF_FFFF,   1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b01000, 32'd1,          32'd1,          32'd0, 32'h8000_0000,   1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b01001, 32'h8000_0001,  32'd4,          32'd0, 32'h0000_0018,   1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b00111, 32'd3,          32'd4,          32'd0, 32'h0000_0030,   1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b00101, 32'h8000_0000,  32'd31,         32'd0, 32'd1,           1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b00110, 32'h8000_0000,  32'd4,          32'd0, 32'hF800_0000,   1'b0, 1'b0, 2};
        vecs[n_vecs++] = '{5'b01111, 32'h0001_0000,  32'h0001_0000,  32'd1, 32'd0,           1'b0, 1'b0, 3};
        vecs[n_vecs++] = '{5'b01111, 32'hFFFF_FFFF,  32'd2,          32'd1, 32'hFFFF_FFFE,   1'b0, 1'b0, 3};
        vecs[n_vecs++] = '{5'b00001, 32'd17,         32'd5,          32'd2, 32'd3,           1'b0, 1'b0, 5};
        vecs[n_vecs++] = '{5'b11111, 32'd9,          32'd9,          32'd0, 32'd0,           1'b1, 1'b0, 1};
        vecs[n_vecs++] = '{5'b00000, 32'd1,          32'd2,          32'd0, 32'd0,           1'b1, 1'b0, 1};
`ifdef ALU_DIVZ_TRAP_EN
        vecs[n_vecs++] = '{5'b00001, 32'd17,         32'd0,          32'd0, 32'd0,           1'b0, 1'b1, 1};
        vecs[n_vecs++] = '{5'b00001, 32'd17,         32'd5,          32'd2, 32'd3,           1'b0, 1'b0, 5};
`else
        vecs[n_vecs++] = '{5'b00001, 32'd17,         32'd0,          32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 5};
`endif

        clear      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 5'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clock);
        check("reset res_valid", 64'(res_valid), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset res_hilo", {res_hi, res_lo}, 64'd0);
        check("reset alu_a", 64'(alu_a), 64'd0);
        clear = 1'b1;

        for (int i = 0; i < n_vecs; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: SUB result held while res_ready stays low, competing request ignored
        @(negedge clock);
        req_opcode = 5'b00100;
        req_a      = 32'd10;
        req_b      = 32'd3;
        req_valid  = 1'b1;
        @(posedge clock);
        #1;
        req_opcode = 5'b01100;
        req_a      = 32'd1;
        req_b      = 32'd1;
        wait_result(5'b00100, 32'd10, 32'd3, n, got);
        check("bp latency", 64'(n), 64'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp res_valid held", 64'(res_valid), 64'd1);
            check("bp res_lo held", 64'(res_lo), 64'd7);
            check("bp req_ready", 64'(req_ready), 64'd0);
            check("bp alu_opcode held", 64'(alu_opcode), 64'b00100);
        end
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        @(negedge clock);
        check("bp idle after release", 64'(busy), 64'd0);
        check("bp no early accept", 64'(alu_opcode), 64'b00100);
        check("bp res_valid drop", 64'(res_valid), 64'd0);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("bp second accepted", 64'(busy), 64'd1);
        check("bp second alu_opcode", 64'(alu_opcode), 64'b01100);
        wait_result(5'b01100, 32'd1, 32'd1, n, got);
        check("bp second latency", 64'(n), 64'd1);
        check("bp second res_lo", 64'(res_lo), 64'd2);
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;

        // Reset in the middle of a DIV: everything clears, no result appears
        @(negedge clock);
        req_opcode = 5'b00001;
        req_a      = 32'd100;
        req_b      = 32'd7;
        req_valid  = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("div busy before reset", 64'(busy), 64'd1);
        #1;
        clear = 1'b0;
        #1;
        check("mid reset res_valid", 64'(res_valid), 64'd0);
        check("mid reset res_hilo", {res_hi, res_lo}, 64'd0);
        check("mid reset alu_ab", {alu_a, alu_b}, 64'd0);
        check("mid reset alu_opcode", 64'(alu_opcode), 64'd0);
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset req_ready", 64'(req_ready), 64'd1);
        @(negedge clock);
        clear = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("post reset no res_valid", 64'(res_valid), 64'd0);
            check("post reset idle", 64'(req_ready), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
